// File: rtl/toa_pkg.sv
// Shared TOA word layout between the encoder and the downstream readout.
// A word is {error, coarse[2:0], fine[6:0]}; the low 10 bits equal coarse*128 + fine.
package toa_pkg;
    localparam int TOA_CODE_W = 10;
    localparam int TOA_WORD_W = 11;
    localparam int ERR_BIT    = 10;
    localparam int COARSE_MSB = 9;
    localparam int COARSE_LSB = 7;
    localparam int FINE_MSB   = 6;
    localparam int FINE_LSB   = 0;

    typedef logic [TOA_WORD_W-1:0] toa_word_t;

    function automatic toa_word_t packToa(input logic [2:0] coarse,
                                          input logic [6:0] fine,
                                          input logic       err);
        toa_word_t w;
        w = '0;
        w[ERR_BIT]                = err;
        w[COARSE_MSB:COARSE_LSB] = coarse;
        w[FINE_MSB:FINE_LSB]     = fine;
        return w;
    endfunction
endpackage

// File: rtl/toa_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; the caller guarantees push only
// when there is room (or a same-cycle pop) and pop only when not empty.
module toa_sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     notEmpty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr, rdPtr;
    logic [WIDTH-1:0] headWord, lastWord;

    assign level    = wrPtr - rdPtr;
    assign notEmpty = (wrPtr != rdPtr);
    assign full     = (wrPtr[AW-1:0] == rdPtr[AW-1:0]) && (wrPtr[AW] != rdPtr[AW]);
    assign headWord = mem[rdPtr[AW-1:0]];
    // When empty the output keeps showing the most recently consumed word.
    assign rdata    = notEmpty ? headWord : lastWord;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            lastWord <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PW'(1);
            if (pop) begin
                rdPtr    <= rdPtr + PW'(1);
                lastWord <= headWord;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wrPtr[AW-1:0]] <= wdata;
    end
endmodule

// File: rtl/toa_hit_buffer.sv
// Captures encoder results on hit strobes, buffers packed TOA words in a FIFO
// and keeps saturating overflow / error statistics.
module toa_hit_buffer
    import toa_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   hit_valid,
    input  logic [2:0]             coarse_phase,
    input  logic [6:0]             fine_phase,
    input  logic                   error_flag,
    input  logic                   drop_error,
    input  logic                   clr_cnt,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOA_WORD_W-1:0]  out_data,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       overflow_cnt,
    output logic [CNT_W-1:0]       error_cnt
);
    toa_word_t hitWord;
    logic      wantPush, push, pop, full, overflow;

    assign hitWord  = packToa(coarse_phase, fine_phase, error_flag);
    assign wantPush = hit_valid && !(drop_error && error_flag);
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts a hit if the head leaves in the same cycle.
    assign push     = wantPush && (!full || pop);
    assign overflow = wantPush && full && !pop;

    toa_sync_fifo #(.WIDTH(TOA_WORD_W), .DEPTH(DEPTH)) uFifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .wdata    (hitWord),
        .pop      (pop),
        .rdata    (out_data),
        .notEmpty (out_valid),
        .full     (full),
        .level    (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_cnt <= '0;
            error_cnt    <= '0;
        end else if (clr_cnt) begin
            overflow_cnt <= '0;
            error_cnt    <= '0;
        end else begin
            if (overflow && overflow_cnt != '1)
                overflow_cnt <= overflow_cnt + CNT_W'(1);
            if (hit_valid && error_flag && error_cnt != '1)
                error_cnt <= error_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/toa_hit_buffer.md
# toa_hit_buffer

Downstream stage of the TOA encoder in the pixel TDC readout chain. Each cycle a hit strobe is asserted, it captures the encoder's combinational result (3-bit coarse phase, 7-bit fine phase, error flag). It packs the result into an 11-bit TOA word and buffers it in a small synchronous FIFO. It presents the words to the readout side over a valid/ready stream, and keeps saturating overflow and error statistics.

## Interface
Parameters:
- DEPTH, 8: FIFO entries; power of two, 2..64.
- CNT_W, 8: width of each statistics counter.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- hit_valid  in  1  one-cycle strobe; encoder outputs are valid this cycle.
- coarse_phase  in  3  encoder outputCoarsePhase.
- fine_phase  in  7  encoder outputFinePhase.
- error_flag  in  1  encoder errorFlag.
- drop_error  in  1  quasi-static config; 1 = do not store hits with error_flag=1.
- clr_cnt  in  1  synchronous clear of both statistics counters.
- out_valid  out  1  head word available.
- out_ready  in  1  consumer accepts head word when out_valid & out_ready.
- out_data  out  11  {error, toa_code[9:0]}, where toa_code = coarse*128 + fine.
- fifo_level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_cnt  out  CNT_W  hits dropped because the FIFO was full.
- error_cnt  out  CNT_W  hits seen with error_flag=1, stored or not.

## Operation
- Packing: toa_code = {coarse_phase, fine_phase}. This is exactly coarse*128 + fine, range 0..1023. Bit 10 = error_flag.
- A hit is stored (push) when all of the following hold:
  - hit_valid=1;
  - !(drop_error & error_flag);
  - the FIFO is not full after accounting for a same-cycle pop.
- Pop = out_valid & out_ready.
- Full with simultaneous push and pop: both succeed and the level stays DEPTH. No overflow is counted.
- Full with push and no pop: the hit is discarded and overflow_cnt increments. The FIFO contents are unchanged.
- Empty: out_valid=0 and out_data holds its last value (0 after reset). A same-cycle pop request is ignored.
- A hit filtered by drop_error never counts as overflow.
- error_cnt increments on every hit_valid with error_flag=1, independent of drop_error or full.
- Counters saturate at 2^CNT_W-1 and never wrap.
- clr_cnt=1 forces both counters to 0 on the next edge. This overrides a same-cycle increment.
- Read and write pointers are $clog2(DEPTH)+1 bits. The MSB distinguishes full from empty, and the pointers wrap modulo 2*DEPTH.
- Order is strict FIFO; no reordering or merging.

## Timing
- Reset (rst_n low, asynchronous assert): out_valid=0, out_data=0, fifo_level=0, overflow_cnt=0, error_cnt=0, pointers=0.
- Reset deassertion is assumed synchronised externally. A reset in mid-operation discards all stored words immediately.
- Latency: a hit pushed at edge N into an empty FIFO gives out_valid=1 with that word after edge N. There is no combinational path from hit_valid to out_valid.
- out_data and out_valid come from registered storage and pointers. out_ready may combinationally affect only the internal pop.
- Throughput: one push and one pop per cycle, sustained.
- fifo_level and the counters update on the same edge as the event that changes them.
- While out_valid=1 and out_ready=0, out_data is stable.

## Structure
- Package toa_pkg:
  - TOA_CODE_W=10, TOA_WORD_W=11;
  - field positions ERR_BIT=10, COARSE_MSB=9, COARSE_LSB=7, FINE_MSB=6;
  - typedef toa_word_t.
- The encoder and downstream readout share toa_pkg.
- Sub-module toa_sync_fifo (parameterised WIDTH, DEPTH) holds storage, pointers and level.
- toa_hit_buffer adds the packing, the filter/push decision and the counters.

## Test plan
- Reset: assert rst_n=0 mid-traffic, then check all outputs read 0 and out_valid=0 on the next sample, with no clock needed.
- Single hit: coarse=3, fine=5, error=0, out_ready=1 -> one cycle later out_valid=1, out_data=0x185. One cycle after that, out_valid=0 and fifo_level=0.
- Fill and overflow:
  - Hold out_ready=0 and push 10 hits with codes 0..9 -> fifo_level=8, overflow_cnt=2.
  - Then set out_ready=1 -> read-out codes 0..7 in order.
- Full with simultaneous push/pop: with the FIFO full and out_ready=1, push code 0x3FF -> level stays 8, overflow_cnt unchanged, 0x3FF appears eighth.
- Error filter:
  - drop_error=1, hit with error_flag=1 -> not stored, error_cnt=1, overflow_cnt=0.
  - drop_error=0, same hit -> stored with out_data[10]=1, error_cnt=2.
- Saturation/clear:
  - 300 overflowing hits -> overflow_cnt=255.
  - clr_cnt in the same cycle as a further overflow -> overflow_cnt=0 next cycle.
